// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: fetch-unit bus bundle (CPU control side + Avalon-MM instruction read port).
//  i_permit_fetch/i_inst_complete/i_redirect/i_redirect_addr : requests from the CPU controller
//  o_inst/o_inst_valid/o_empty/o_fetch_complete/o_pc       : FIFO head and status to decode/controller
//  o_avm_*/i_avm_*                                         : Avalon-MM burst read port to instruction memory
//  slave modport is taken by the fetch unit, master modport by its environment.
interface inst_fetch_unit_if #(
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 32
);
    logic                 i_permit_fetch;
    logic                 i_inst_complete;
    logic                 i_redirect;
    logic [ADDR_BITS-1:0] i_redirect_addr;
    logic [WORD_BITS-1:0] o_inst;
    logic                 o_inst_valid;
    logic                 o_empty;
    logic                 o_fetch_complete;
    logic [ADDR_BITS-1:0] o_pc;
    logic [ADDR_BITS-1:0] o_avm_address;
    logic                 o_avm_read;
    logic [7:0]           o_avm_burstcount;
    logic                 i_avm_waitrequest;
    logic [WORD_BITS-1:0] i_avm_readdata;
    logic                 i_avm_readdatavalid;

    modport slave (
        input  i_permit_fetch, i_inst_complete, i_redirect, i_redirect_addr,
               i_avm_waitrequest, i_avm_readdata, i_avm_readdatavalid,
        output o_inst, o_inst_valid, o_empty, o_fetch_complete, o_pc,
               o_avm_address, o_avm_read, o_avm_burstcount
    );

    modport master (
        output i_permit_fetch, i_inst_complete, i_redirect, i_redirect_addr,
               i_avm_waitrequest, i_avm_readdata, i_avm_readdatavalid,
        input  o_inst, o_inst_valid, o_empty, o_fetch_complete, o_pc,
               o_avm_address, o_avm_read, o_avm_burstcount
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: turns CPU fetch permits into Avalon-MM read bursts and buffers words in a FIFO.
//  clk : clock
//  rst : asynchronous active-low reset (0 = reset)
//  bus : inst_fetch_unit_if.slave (controller handshake, FIFO head/status, Avalon read port)
module inst_fetch_unit #(
    parameter int                   WORD_BITS    = 32,
    parameter int                   ADDR_BITS    = 32,
    parameter int                   BURST_LENGTH = 4,
    parameter int                   FIFO_DEPTH   = 8,
    parameter logic [ADDR_BITS-1:0] RESET_PC     = '0
) (
    input logic              clk,
    input logic              rst,
    inst_fetch_unit_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LENGTH + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [PW:0]          SPACE_MAX   = (PW+1)'(FIFO_DEPTH - BURST_LENGTH);
    localparam logic [BW-1:0]        LAST_BEAT   = BW'(BURST_LENGTH - 1);
    localparam logic [ADDR_BITS-1:0] BURST_BYTES = ADDR_BITS'(BURST_LENGTH * WORD_BITS / 8);
    localparam logic [ADDR_BITS-1:0] WORD_BYTES  = ADDR_BITS'(WORD_BITS / 8);

    logic [2:0]           r_state;
    logic [WORD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_head, r_tail;
    logic [PW:0]          r_count;
    logic [BW-1:0]        r_beat;
    logic [ADDR_BITS-1:0] r_fetch_addr, r_pc, r_avm_address;
    logic                 r_avm_read, r_permit_d, r_pending, r_kill;
    logic                 w_empty, w_last, w_issue, w_accept, w_push, w_pop, w_redir, w_beat;

    assign w_redir  = bus.i_redirect;
    assign w_beat   = bus.i_avm_readdatavalid;
    assign w_empty  = r_count == '0;
    assign w_last   = r_beat == LAST_BEAT;
    // A burst is only issued when the whole burst is guaranteed to fit, so pushes never overflow.
    assign w_issue  = r_state == S_IDLE && r_pending && !w_redir && r_count <= SPACE_MAX;
    assign w_accept = r_state == S_REQ && !bus.i_avm_waitrequest;
    assign w_push   = r_state == S_DATA && w_beat && !w_redir;
    assign w_pop    = bus.i_inst_complete && !w_empty && !w_redir;

    assign bus.o_inst           = w_empty ? '0 : r_mem[r_head];
    assign bus.o_inst_valid     = !w_empty;
    assign bus.o_empty          = w_empty;
    assign bus.o_fetch_complete = r_state == S_DONE;
    assign bus.o_pc             = r_pc;
    assign bus.o_avm_address    = r_avm_address;
    assign bus.o_avm_read       = r_avm_read;
    assign bus.o_avm_burstcount = 8'(BURST_LENGTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pc    <= RESET_PC;
        end else if (w_redir) begin
            r_head  <= r_tail;
            r_count <= '0;
            r_pc    <= bus.i_redirect_addr;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop) begin
                r_head <= r_head + PW'(1);
                r_pc   <= r_pc + WORD_BYTES;
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= bus.i_avm_readdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_avm_read    <= 1'b0;
            r_avm_address <= RESET_PC;
            r_fetch_addr  <= RESET_PC;
            r_pending     <= 1'b0;
            r_permit_d    <= 1'b0;
            r_beat        <= '0;
            r_kill        <= 1'b0;
        end else begin
            r_permit_d <= bus.i_permit_fetch;
            r_pending  <= !w_redir && !w_issue && (r_pending || (bus.i_permit_fetch && !r_permit_d));
            // A burst killed by a redirect must not advance the new target address.
            if (w_redir) r_fetch_addr <= bus.i_redirect_addr;
            else if (w_accept && !r_kill) r_fetch_addr <= r_fetch_addr + BURST_BYTES;
            case (r_state)
                S_IDLE: if (w_issue) begin
                    r_state       <= S_REQ;
                    r_avm_read    <= 1'b1;
                    r_avm_address <= r_fetch_addr;
                    r_beat        <= '0;
                end
                // The read must stay up until accepted; a redirect meanwhile only marks the burst dead.
                S_REQ: if (w_accept) begin
                    r_avm_read <= 1'b0;
                    r_kill     <= 1'b0;
                    r_state    <= (r_kill || w_redir) ? S_DRAIN : S_DATA;
                end else if (w_redir) r_kill <= 1'b1;
                // A redirect on the final beat has nothing left to drain.
                S_DATA: if (w_beat) begin
                    r_beat  <= r_beat + BW'(1);
                    r_state <= w_last ? (w_redir ? S_IDLE : S_DONE) : (w_redir ? S_DRAIN : S_DATA);
                end else if (w_redir) r_state <= S_DRAIN;
                S_DONE: r_state <= S_IDLE;
                S_DRAIN: if (w_beat) begin
                    r_beat <= r_beat + BW'(1);
                    if (w_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus randomized traffic against a queue-based fetch model.
module tb_inst_fetch_unit;
    typedef struct {
        logic [31:0] addr;
        bit          live;
        bit          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_unit_if bus ();
    inst_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_cmp = 0, n_bad = 0;
    beat_t       beats[$];
    logic [31:0] q[$];
    logic [31:0] m_pc = 0, m_fa = 0, last_acc_addr = 0, prev_addr = 0;
    bit          m_kill = 0, rand_gap = 0, rand_wait = 0, prev_rd = 0;
    int          force_wait = 0, n_acc = 0, n_fc = 0, n_read_cycles = 0, n_unstable = 0;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc = 0;
        m_fa = 0;
        m_kill = 0;
        foreach (beats[i]) beats[i].live = 0;
    endtask

    // One clock: memory responds, edge, then model update and per-cycle checks.
    task automatic tick();
        bit rdv, acc, red, pop, rd_pre, fc_exp;
        logic [31:0] ra, aaddr;
        int lv;
        rdv = beats.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0);
        bus.i_avm_readdatavalid = rdv;
        if (rdv) bus.i_avm_readdata = memfn(beats[0].addr);
        else bus.i_avm_readdata = $urandom;
        if (rand_wait) bus.i_avm_waitrequest = 1'($urandom_range(0, 1));
        else bus.i_avm_waitrequest = bus.o_avm_read && force_wait > 0;
        rd_pre = bus.o_avm_read;
        aaddr  = bus.o_avm_address;
        acc    = rd_pre && !bus.i_avm_waitrequest;
        red    = bus.i_redirect;
        ra     = bus.i_redirect_addr;
        pop    = bus.i_inst_complete;
        if (rd_pre) n_read_cycles++;
        if (rd_pre && prev_rd && aaddr != prev_addr) n_unstable++;
        prev_rd = rd_pre;
        prev_addr = aaddr;
        if (rd_pre && bus.i_avm_waitrequest && force_wait > 0) force_wait--;
        @(posedge clk);
        #1;
        fc_exp = 0;
        if (red) begin
            q.delete();
            m_pc = ra;
            m_fa = ra;
            foreach (beats[i]) beats[i].live = 0;
        end else begin
            if (pop && q.size() > 0) begin
                void'(q.pop_front());
                m_pc += 4;
            end
            if (rdv && beats[0].live) begin
                q.push_back(memfn(beats[0].addr));
                fc_exp = beats[0].last;
            end
        end
        if (rdv) void'(beats.pop_front());
        if (acc) begin
            n_acc++;
            last_acc_addr = aaddr;
            for (int i = 0; i < 4; i++) beats.push_back('{addr: aaddr + 32'(4 * i), live: !(m_kill || red), last: i == 3});
            if (!(m_kill || red)) m_fa += 16;
            m_kill = 0;
        end else if (red && rd_pre) m_kill = 1;
        n_cmp++;
        if (bus.o_empty !== (q.size() == 0) || bus.o_inst_valid !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL status: o_empty=%b o_inst_valid=%b, model holds %0d words", bus.o_empty, bus.o_inst_valid, q.size());
        end
        n_cmp++;
        if (bus.o_pc !== m_pc) begin
            n_bad++;
            $display("FAIL pc: got %h want %h", bus.o_pc, m_pc);
        end
        n_cmp++;
        if (bus.o_inst !== (q.size() != 0 ? q[0] : 32'h0)) begin
            n_bad++;
            $display("FAIL inst: got %h want %h", bus.o_inst, q.size() != 0 ? q[0] : 32'h0);
        end
        n_cmp++;
        if (bus.o_fetch_complete !== fc_exp) begin
            n_bad++;
            $display("FAIL fetch_complete: got %b want %b", bus.o_fetch_complete, fc_exp);
        end
        if (bus.o_avm_read && !rd_pre) begin
            n_cmp++;
            if (bus.o_avm_address !== m_fa || bus.o_avm_burstcount !== 8'd4) begin
                n_bad++;
                $display("FAIL issue: addr %h burst %0d want addr %h burst 4", bus.o_avm_address, bus.o_avm_burstcount, m_fa);
            end
        end
        lv = 0;
        foreach (beats[i]) lv += int'(beats[i].live);
        n_cmp++;
        if (q.size() + lv > 8) begin
            n_bad++;
            $display("FAIL space: %0d buffered + %0d in flight exceeds 8", q.size(), lv);
        end
        if (bus.o_fetch_complete) n_fc++;
    endtask

    task automatic permit_pulse();
        bus.i_permit_fetch = 1;
        tick();
        bus.i_permit_fetch = 0;
    endtask

    task automatic wait_complete(input string name);
        for (int k = 0; k < 60 && !bus.o_fetch_complete; k++) tick();
        n_cmp++;
        if (!bus.o_fetch_complete) begin
            n_bad++;
            $display("FAIL %s timeout: fetch_complete got 0 want 1", name);
        end
    endtask

    // Pops n words: FIFO must still be non-empty after n-1 pops and empty after n.
    task automatic drain_check(input string name, input int n);
        bus.i_inst_complete = 1;
        for (int k = 0; k < n - 1; k++) tick();
        n_cmp++;
        if (bus.o_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL %s count: empty after %0d pops, got o_empty=%b want 0", name, n - 1, bus.o_empty);
        end
        tick();
        bus.i_inst_complete = 0;
        n_cmp++;
        if (bus.o_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL %s count: after %0d pops got o_empty=%b want 1", name, n, bus.o_empty);
        end
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_empty !== 1 || bus.o_inst_valid !== 0 || bus.o_inst !== 0 || bus.o_fetch_complete !== 0) begin
            n_bad++;
            $display("FAIL reset status: empty=%b valid=%b inst=%h fc=%b want 1 0 0 0", bus.o_empty, bus.o_inst_valid, bus.o_inst, bus.o_fetch_complete);
        end
        n_cmp++;
        if (bus.o_avm_read !== 0 || bus.o_avm_address !== 0 || bus.o_pc !== 0 || bus.o_avm_burstcount !== 8'd4) begin
            n_bad++;
            $display("FAIL reset bus: read=%b addr=%h pc=%h burst=%0d want 0 0 0 4", bus.o_avm_read, bus.o_avm_address, bus.o_pc, bus.o_avm_burstcount);
        end
        rst = 1;
        model_reset();
        repeat (2) tick();
    endtask

    task automatic test_single_burst();
        int a0, f0;
        a0 = n_acc;
        f0 = n_fc;
        permit_pulse();
        wait_complete("single");
        repeat (3) tick();
        n_cmp++;
        if (n_acc - a0 != 1 || last_acc_addr !== 32'h0 || n_fc - f0 != 1) begin
            n_bad++;
            $display("FAIL single: reads %0d addr %h pulses %0d want 1 0 1", n_acc - a0, last_acc_addr, n_fc - f0);
        end
        n_cmp++;
        if (bus.o_pc !== 32'h0 || bus.o_inst !== memfn(32'h0)) begin
            n_bad++;
            $display("FAIL single head: pc %h inst %h want 0 %h", bus.o_pc, bus.o_inst, memfn(32'h0));
        end
    endtask

    task automatic test_waitrequest();
        int a0, r0;
        a0 = n_acc;
        r0 = n_read_cycles;
        n_unstable = 0;
        force_wait = 3;
        permit_pulse();
        wait_complete("waitreq");
        n_cmp++;
        if (n_read_cycles - r0 != 4 || n_acc - a0 != 1 || n_unstable != 0) begin
            n_bad++;
            $display("FAIL waitreq: read cycles %0d accepts %0d unstable %0d want 4 1 0", n_read_cycles - r0, n_acc - a0, n_unstable);
        end
        n_cmp++;
        if (last_acc_addr !== 32'h10) begin
            n_bad++;
            $display("FAIL waitreq addr: got %h want 00000010", last_acc_addr);
        end
    endtask

    task automatic test_space();
        int a0, r0;
        bus.i_inst_complete = 1;
        repeat (2) tick();
        bus.i_inst_complete = 0;
        a0 = n_acc;
        r0 = n_read_cycles;
        permit_pulse();
        repeat (6) tick();
        bus.i_inst_complete = 1;
        tick();
        bus.i_inst_complete = 0;
        repeat (3) tick();
        n_cmp++;
        if (n_read_cycles - r0 != 0) begin
            n_bad++;
            $display("FAIL space hold: read asserted %0d cycles with 5 words buffered, want 0", n_read_cycles - r0);
        end
        bus.i_inst_complete = 1;
        tick();
        bus.i_inst_complete = 0;
        wait_complete("space");
        n_cmp++;
        if (n_acc - a0 != 1 || last_acc_addr !== 32'h20) begin
            n_bad++;
            $display("FAIL space issue: reads %0d addr %h want 1 00000020", n_acc - a0, last_acc_addr);
        end
        drain_check("space", 8);
        n_cmp++;
        if (bus.o_pc !== 32'h30) begin
            n_bad++;
            $display("FAIL space pc: got %h want 00000030", bus.o_pc);
        end
    endtask

    task automatic test_redirect();
        int f0;
        permit_pulse();
        for (int k = 0; k < 30 && beats.size() != 2; k++) tick();
        f0 = n_fc;
        bus.i_redirect = 1;
        bus.i_redirect_addr = 32'h100;
        tick();
        bus.i_redirect = 0;
        n_cmp++;
        if (bus.o_empty !== 1 || bus.o_pc !== 32'h100) begin
            n_bad++;
            $display("FAIL redirect: empty %b pc %h want 1 00000100", bus.o_empty, bus.o_pc);
        end
        repeat (5) tick();
        n_cmp++;
        if (n_fc != f0 || bus.o_empty !== 1) begin
            n_bad++;
            $display("FAIL redirect drain: pulses %0d empty %b want 0 1", n_fc - f0, bus.o_empty);
        end
        permit_pulse();
        wait_complete("redirect");
        n_cmp++;
        if (last_acc_addr !== 32'h100 || bus.o_pc !== 32'h100 || bus.o_inst !== memfn(32'h100)) begin
            n_bad++;
            $display("FAIL redirect refetch: addr %h pc %h inst %h want 100 100 %h", last_acc_addr, bus.o_pc, bus.o_inst, memfn(32'h100));
        end
    endtask

    task automatic test_push_pop();
        bus.i_inst_complete = 1;
        tick();
        bus.i_inst_complete = 0;
        permit_pulse();
        for (int k = 0; k < 20 && beats.size() == 0; k++) tick();
        bus.i_inst_complete = 1;
        tick();
        bus.i_inst_complete = 0;
        n_cmp++;
        if (bus.o_pc !== 32'h108 || bus.o_inst !== memfn(32'h108)) begin
            n_bad++;
            $display("FAIL push_pop: pc %h inst %h want 108 %h", bus.o_pc, bus.o_inst, memfn(32'h108));
        end
        wait_complete("push_pop");
        drain_check("push_pop", 6);
    endtask

    task automatic test_async_reset();
        int f0, r0;
        permit_pulse();
        for (int k = 0; k < 30 && beats.size() != 3; k++) tick();
        #2;
        rst = 0;
        #1;
        n_cmp++;
        if (bus.o_empty !== 1 || bus.o_inst_valid !== 0 || bus.o_inst !== 0 || bus.o_fetch_complete !== 0 ||
            bus.o_avm_read !== 0 || bus.o_avm_address !== 0 || bus.o_pc !== 0) begin
            n_bad++;
            $display("FAIL async reset: empty=%b valid=%b inst=%h fc=%b read=%b addr=%h pc=%h", bus.o_empty, bus.o_inst_valid,
                     bus.o_inst, bus.o_fetch_complete, bus.o_avm_read, bus.o_avm_address, bus.o_pc);
        end
        model_reset();
        bus.i_avm_readdatavalid = 0;
        @(posedge clk);
        #1;
        rst = 1;
        f0 = n_fc;
        r0 = n_read_cycles;
        for (int k = 0; k < 10 && beats.size() != 0; k++) tick();
        repeat (4) tick();
        n_cmp++;
        if (n_fc != f0 || n_read_cycles != r0 || bus.o_empty !== 1) begin
            n_bad++;
            $display("FAIL late beats: pulses %0d reads %0d empty %b want 0 0 1", n_fc - f0, n_read_cycles - r0, bus.o_empty);
        end
    endtask

    task automatic test_random();
        int f0;
        f0 = n_fc;
        rand_gap = 1;
        rand_wait = 1;
        for (int k = 0; k < 3000; k++) begin
            bus.i_permit_fetch  = $urandom_range(0, 3) == 0;
            bus.i_inst_complete = 1'($urandom_range(0, 1));
            bus.i_redirect      = $urandom_range(0, 49) == 0;
            bus.i_redirect_addr = ($urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 4095))) & 32'hFFFF_FFFC;
            tick();
        end
        bus.i_permit_fetch = 0;
        bus.i_inst_complete = 0;
        bus.i_redirect = 0;
        rand_gap = 0;
        rand_wait = 0;
        n_cmp++;
        if (n_fc - f0 < 20) begin
            n_bad++;
            $display("FAIL random activity: only %0d completed bursts", n_fc - f0);
        end
    endtask

    initial begin
        bus.i_permit_fetch = 0;
        bus.i_inst_complete = 0;
        bus.i_redirect = 0;
        bus.i_redirect_addr = 0;
        bus.i_avm_waitrequest = 0;
        bus.i_avm_readdata = 0;
        bus.i_avm_readdatavalid = 0;
        test_reset();
        test_single_burst();
        test_waitrequest();
        test_space();
        test_redirect();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
